ctrl_aut: RTL and testbench
===========================

Name: ctrl_aut

Overview:
- Multi-cycle control automaton that sits directly upstream of the datapath automaton (op_aut).
- Consumes the datapath's opcode, funct and zero outputs.
- Sequences each instruction through FETCH/DECODE/EXEC/COMMIT and drives every datapath control input: PC load, register write, mux selects and ALU function.
- Adds run/stall control, illegal-instruction trap and a retired-instruction counter.

Parameters:
- CntWidth, 32, width of the retired-instruction counter.
- TrapOnIllegal, 1, 1 = illegal opcode/funct enters TRAP; 0 = treat it as a NOP (PC advances, no write).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  1 = start the next instruction; sampled only in FETCH.
- opcode  in  6  instruction[31:26] from the datapath.
- funct  in  6  instruction[5:0] from the datapath.
- zero  in  1  ALU zero flag from the datapath.
- pc_load  out  1  PC register load enable.
- rd_mux_s  out  1  destination select: 0 = rt, 1 = rd.
- write  out  1  register file write enable.
- op2_mux_s  out  1  ALU operand 2 select: 0 = rdata2, 1 = sign-extended immediate.
- alu_funct  out  6  ALU operation, MIPS funct encoding.
- branch_mux_s  out  1  1 = take the branch target.
- j_mux_s  out  1  1 = take the jump target.
- halted  out  1  1 while in TRAP.
- state  out  2  current state, for debug.
- retired  out  CntWidth  count of committed instructions.

Behaviour:
- Reset (asynchronous, active-low):
  - state = FETCH; retired = 0; latched opcode/funct/zero = 0.
  - All control outputs = 0, halted = 0. Outputs clear immediately on assertion, without waiting for a clock edge.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, COMMIT = 3. TRAP shares code 3, and `state` reads 3 with halted = 1.
- FETCH: run = 1 → DECODE; run = 0 → stay in FETCH. All control outputs are 0.
- DECODE: latch opcode and funct into ir_op/ir_fn; next state is EXEC.
- EXEC:
  - rd_mux_s, op2_mux_s and alu_funct are driven from the latched fields and held stable from this state through COMMIT.
  - At the EXEC→COMMIT edge, zero is sampled into zero_q.
  - Illegal instruction with TrapOnIllegal = 1 → TRAP; otherwise → COMMIT.
- COMMIT (exactly one cycle):
  - pc_load = 1.
  - write = 1 for ALU-class instructions.
  - branch_mux_s and j_mux_s are driven per the decode table below.
  - retired increments by 1 and wraps from all-ones to 0.
  - Next state is FETCH.
- TRAP: all control outputs 0, halted = 1. The only exit is reset.
- Latency: 4 cycles per instruction when run is held at 1. PC changes on the clock edge that ends COMMIT.
- Decode table (hex values):
  - R-type, opcode 00:
    - Legal funct values: 20 add, 22 sub, 24 and, 25 or, 2A slt.
    - Drive: alu_funct = funct, rd_mux_s = 1, op2_mux_s = 0, write = 1.
  - addi, opcode 08: alu_funct = 20, op2_mux_s = 1, rd_mux_s = 0, write = 1.
  - slti, opcode 0A: alu_funct = 2A, op2_mux_s = 1, rd_mux_s = 0, write = 1.
  - beq, opcode 04: alu_funct = 22, op2_mux_s = 0, branch_mux_s = zero_q.
  - bne, opcode 05: alu_funct = 22, op2_mux_s = 0, branch_mux_s = ~zero_q.
  - j, opcode 02: j_mux_s = 1; the ALU fields are don't-care and are driven to 0.
  - Any other opcode, or an R-type with an unlisted funct, is illegal.
- Illegal instruction with TrapOnIllegal = 0: COMMIT asserts pc_load only, and retired still increments.
- run deasserted mid-instruction: ignored; the in-flight instruction completes and the FSM then waits in FETCH.
- zero toggling outside the EXEC→COMMIT edge has no effect.
- Reset asserted in COMMIT: write and pc_load drop immediately, and retired does not increment.
- write and pc_load are never asserted outside COMMIT.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_SLTI, OP_BEQ, OP_BNE, OP_J;
  - funct/ALU constants: F_ADD, F_SUB, F_AND, F_OR, F_SLT;
  - state encodings.
- One combinational sub-module, ctrl_decode:
  - inputs: ir_op, ir_fn, zero_q;
  - outputs: the control bundle plus a legal flag.
- ctrl_aut keeps the FSM, the latches and the counter.

Test Plan:
- Reset low, then high with run = 1 and opcode 00 / funct 20: the cycle after reset release is FETCH; 3 cycles later in COMMIT, write = 1, rd_mux_s = 1, alu_funct = 20, pc_load = 1; retired = 1 after COMMIT.
- addi (08) followed by j (02), run held at 1: addi COMMIT gives op2_mux_s = 1, write = 1, rd_mux_s = 0; j COMMIT gives j_mux_s = 1, write = 0; retired = 2 after 8 cycles.
- beq with zero = 1 at EXEC: branch_mux_s = 1 in COMMIT. bne with zero = 1: branch_mux_s = 0. bne with zero toggling 0→1 during DECODE but 0 at the EXEC edge: branch_mux_s = 1.
- run = 0 for 5 cycles: state stays at 0 and pc_load stays 0. run deasserted during DECODE: the instruction still commits, then the FSM waits in FETCH.
- Opcode 3F with TrapOnIllegal = 1: halted = 1 two cycles after DECODE and never leaves; reset restores FETCH. With TrapOnIllegal = 0: pc_load = 1, write = 0, retired increments.
- CntWidth = 4, retired preloaded to 15 via 15 NOP-class commits: the next commit wraps it to 0. Reset asserted mid-COMMIT: write = 0 immediately and retired = 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants and types for the ctrl_aut control automaton:
// MIPS opcode/funct encodings, FSM state codes and the control bundle.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  // TRAP's low two bits alias COMMIT so the debug state port reads 3 while halted.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_COMMIT = 3'd3,
    S_TRAP   = 3'd7
  } state_e;

  typedef struct packed {
    logic       rd_mux_s;
    logic       write;
    logic       op2_mux_s;
    logic [5:0] alu_funct;
    logic       branch_mux_s;
    logic       j_mux_s;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: maps the latched opcode/funct and the
// sampled zero flag to the datapath control bundle plus a legality flag.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] ir_op,
  input  logic [5:0] ir_fn,
  input  logic       zero_q,
  output ctrl_t      ctrl,
  output logic       legal
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    ctrl  = '0;
    legal = 1'b1;
    case (ir_op)
      OP_RTYPE: begin
        case (ir_fn)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
            ctrl.alu_funct = ir_fn;
            ctrl.rd_mux_s  = 1'b1;
            ctrl.write     = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl.alu_funct = F_ADD;
        ctrl.op2_mux_s = 1'b1;
        ctrl.write     = 1'b1;
      end
      OP_SLTI: begin
        ctrl.alu_funct = F_SLT;
        ctrl.op2_mux_s = 1'b1;
        ctrl.write     = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_funct    = F_SUB;
        ctrl.branch_mux_s = zero_q;
      end
      OP_BNE: begin
        ctrl.alu_funct    = F_SUB;
        ctrl.branch_mux_s = ~zero_q;
      end
      OP_J:    ctrl.j_mux_s = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_aut.sv
// Multi-cycle control automaton: FETCH/DECODE/EXEC/COMMIT sequencing, instruction
// latch, illegal-instruction trap and retired-instruction counter for op_aut.
module ctrl_aut
  import ctrl_pkg::*;
#(
  parameter int CntWidth      = 32,
  parameter bit TrapOnIllegal = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic                pc_load,
  output logic                rd_mux_s,
  output logic                write,
  output logic                op2_mux_s,
  output logic [5:0]          alu_funct,
  output logic                branch_mux_s,
  output logic                j_mux_s,
  output logic                halted,
  output logic [1:0]          state,
  output logic [CntWidth-1:0] retired
);

  state_e     st;
  logic [5:0] ir_op;
  logic [5:0] ir_fn;
  logic       zero_q;
  ctrl_t      dec;
  logic       legal;

  ctrl_decode u_decode (
    .ir_op  (ir_op),
    .ir_fn  (ir_fn),
    .zero_q (zero_q),
    .ctrl   (dec),
    .legal  (legal)
  );

  // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st      <= S_FETCH;
      ir_op   <= '0;
      ir_fn   <= '0;
      zero_q  <= 1'b0;
      retired <= '0;
    end else begin
      case (st)
        S_FETCH:  if (run) st <= S_DECODE;
        S_DECODE: begin
          ir_op <= opcode;
          ir_fn <= funct;
          st    <= S_EXEC;
        end
        S_EXEC: begin
          zero_q <= zero;
          st     <= (!legal && TrapOnIllegal) ? S_TRAP : S_COMMIT;
        end
        S_COMMIT: begin
          retired <= retired + CntWidth'(1);
          st      <= S_FETCH;
        end
        default:  st <= S_TRAP;
      endcase
    end
  end

  // Outputs depend only on flops, so reset clears them asynchronously and no
  // input reaches an output combinationally.
  logic in_exec_commit;
  logic in_commit;

  always_comb begin
    in_exec_commit = (st == S_EXEC) || (st == S_COMMIT);
    in_commit      = (st == S_COMMIT);
    rd_mux_s       = in_exec_commit & dec.rd_mux_s;
    op2_mux_s      = in_exec_commit & dec.op2_mux_s;
    alu_funct      = in_exec_commit ? dec.alu_funct : 6'h00;
    pc_load        = in_commit;
    write          = in_commit & dec.write;
    branch_mux_s   = in_commit & dec.branch_mux_s;
    j_mux_s        = in_commit & dec.j_mux_s;
    halted         = (st == S_TRAP);
    state          = st[1:0];
  end

endmodule

// File: tb/tb_ctrl_aut.sv
// Directed self-checking bench for ctrl_aut: dut_a traps on illegal opcodes with a
// 32-bit counter, dut_b treats them as NOPs with a 4-bit counter; both share stimulus.
module tb_ctrl_aut;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;

  logic        a_pc_load, a_rd_mux_s, a_write, a_op2_mux_s, a_branch_mux_s, a_j_mux_s, a_halted;
  logic [5:0]  a_alu_funct;
  logic [1:0]  a_state;
  logic [31:0] a_retired;

  logic        b_pc_load, b_rd_mux_s, b_write, b_op2_mux_s, b_branch_mux_s, b_j_mux_s, b_halted;
  logic [5:0]  b_alu_funct;
  logic [1:0]  b_state;
  logic [3:0]  b_retired;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ctrl_aut #(.CntWidth(32), .TrapOnIllegal(1'b1)) dut_a (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_load(a_pc_load), .rd_mux_s(a_rd_mux_s), .write(a_write), .op2_mux_s(a_op2_mux_s),
    .alu_funct(a_alu_funct), .branch_mux_s(a_branch_mux_s), .j_mux_s(a_j_mux_s),
    .halted(a_halted), .state(a_state), .retired(a_retired)
  );

  ctrl_aut #(.CntWidth(4), .TrapOnIllegal(1'b0)) dut_b (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_load(b_pc_load), .rd_mux_s(b_rd_mux_s), .write(b_write), .op2_mux_s(b_op2_mux_s),
    .alu_funct(b_alu_funct), .branch_mux_s(b_branch_mux_s), .j_mux_s(b_j_mux_s),
    .halted(b_halted), .state(b_state), .retired(b_retired)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", a_state); end
    n_checks++; if (a_retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", a_retired); end
    n_checks++; if ({a_pc_load, a_write, a_rd_mux_s, a_op2_mux_s, a_branch_mux_s, a_j_mux_s, a_halted} !== 7'b0)
      begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {a_pc_load, a_write, a_rd_mux_s, a_op2_mux_s, a_branch_mux_s, a_j_mux_s, a_halted}); end
    n_checks++; if (a_alu_funct !== 6'h00) begin n_fail++; $display("FAIL reset_alu: got %h expected 00", a_alu_funct); end
  endtask

  task automatic test_rtype_add;
    @(negedge clock);
    reset = 1'b1; run = 1'b1; opcode = 6'h00; funct = 6'h20;
    n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL add_fetch_state: got %0d expected 0", a_state); end
    step(1);
    n_checks++; if (a_state !== 2'd1) begin n_fail++; $display("FAIL add_decode_state: got %0d expected 1", a_state); end
    step(1);
    run = 1'b0;
    n_checks++; if (a_state !== 2'd2) begin n_fail++; $display("FAIL add_exec_state: got %0d expected 2", a_state); end
    n_checks++; if ({a_rd_mux_s, a_alu_funct, a_write, a_pc_load} !== {1'b1, 6'h20, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL add_exec_ctrl: rd=%b alu=%h wr=%b pc=%b expected rd=1 alu=20 wr=0 pc=0",
        a_rd_mux_s, a_alu_funct, a_write, a_pc_load); end
    step(1);
    n_checks++; if ({a_state, a_write, a_rd_mux_s, a_alu_funct, a_pc_load, a_op2_mux_s} !== {2'd3, 1'b1, 1'b1, 6'h20, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL add_commit_ctrl: st=%0d wr=%b rd=%b alu=%h pc=%b op2=%b expected st=3 wr=1 rd=1 alu=20 pc=1 op2=0",
        a_state, a_write, a_rd_mux_s, a_alu_funct, a_pc_load, a_op2_mux_s); end
    n_checks++; if (a_retired !== 32'd0) begin n_fail++; $display("FAIL add_commit_retired: got %0d expected 0", a_retired); end
    step(1);
    n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL add_after_state: got %0d expected 0", a_state); end
    n_checks++; if (a_retired !== 32'd1) begin n_fail++; $display("FAIL add_after_retired: got %0d expected 1", a_retired); end
  endtask

  task automatic test_back_to_back;
    run = 1'b1; opcode = 6'h08; funct = 6'h00;
    step(3);
    n_checks++; if ({a_op2_mux_s, a_write, a_rd_mux_s, a_alu_funct, a_pc_load, a_j_mux_s} !== {1'b1, 1'b1, 1'b0, 6'h20, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL addi_commit: op2=%b wr=%b rd=%b alu=%h pc=%b j=%b expected op2=1 wr=1 rd=0 alu=20 pc=1 j=0",
        a_op2_mux_s, a_write, a_rd_mux_s, a_alu_funct, a_pc_load, a_j_mux_s); end
    opcode = 6'h02;
    step(1);
    n_checks++; if (a_retired !== 32'd2) begin n_fail++; $display("FAIL addi_retired: got %0d expected 2", a_retired); end
    step(3);
    run = 1'b0;
    n_checks++; if ({a_j_mux_s, a_write, a_pc_load, a_alu_funct, a_op2_mux_s} !== {1'b1, 1'b0, 1'b1, 6'h00, 1'b0})
      begin n_fail++; $display("FAIL j_commit: j=%b wr=%b pc=%b alu=%h op2=%b expected j=1 wr=0 pc=1 alu=00 op2=0",
        a_j_mux_s, a_write, a_pc_load, a_alu_funct, a_op2_mux_s); end
    step(1);
    n_checks++; if (a_retired !== 32'd3) begin n_fail++; $display("FAIL b2b_retired: got %0d expected 3", a_retired); end
  endtask

  task automatic test_branch;
    // {opcode, zero during DECODE, zero at EXEC edge, expected branch_mux_s}
    logic [8:0] vec [3];
    vec[0] = {6'h04, 1'b0, 1'b1, 1'b1};
    vec[1] = {6'h05, 1'b0, 1'b1, 1'b0};
    vec[2] = {6'h05, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run = 1'b1; opcode = vec[i][8:3]; zero = 1'b0;
      step(1);
      run = 1'b0; zero = vec[i][2];
      step(1);
      zero = vec[i][1];
      step(1);
      n_checks++; if ({a_branch_mux_s, a_alu_funct, a_write, a_pc_load} !== {vec[i][0], 6'h22, 1'b0, 1'b1})
        begin n_fail++; $display("FAIL branch_%0d_commit: br=%b alu=%h wr=%b pc=%b expected br=%b alu=22 wr=0 pc=1",
          i, a_branch_mux_s, a_alu_funct, a_write, a_pc_load, vec[i][0]); end
      zero = ~vec[i][1];
      #1;
      n_checks++; if (a_branch_mux_s !== vec[i][0])
        begin n_fail++; $display("FAIL branch_%0d_zero_late: got %b expected %b", i, a_branch_mux_s, vec[i][0]); end
      zero = 1'b0;
      step(1);
    end
    n_checks++; if (a_retired !== 32'd6) begin n_fail++; $display("FAIL branch_retired: got %0d expected 6", a_retired); end
  endtask

  task automatic test_run_stall;
    opcode = 6'h00; funct = 6'h22;
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_checks++; if ({a_state, a_pc_load} !== {2'd0, 1'b0})
        begin n_fail++; $display("FAIL stall_%0d: st=%0d pc=%b expected st=0 pc=0", i, a_state, a_pc_load); end
    end
    run = 1'b1;
    step(1);
    run = 1'b0;
    step(2);
    n_checks++; if ({a_pc_load, a_write, a_alu_funct, a_rd_mux_s} !== {1'b1, 1'b1, 6'h22, 1'b1})
      begin n_fail++; $display("FAIL sub_commit: pc=%b wr=%b alu=%h rd=%b expected pc=1 wr=1 alu=22 rd=1",
        a_pc_load, a_write, a_alu_funct, a_rd_mux_s); end
    step(2);
    n_checks++; if ({a_state, a_retired} !== {2'd0, 32'd7})
      begin n_fail++; $display("FAIL stall_wait: st=%0d retired=%0d expected st=0 retired=7", a_state, a_retired); end
  endtask

  task automatic test_trap;
    run = 1'b1; opcode = 6'h3F; funct = 6'h00;
    step(1);
    run = 1'b0;
    step(1);
    n_checks++; if (a_state !== 2'd2) begin n_fail++; $display("FAIL trap_exec_state: got %0d expected 2", a_state); end
    step(1);
    n_checks++; if ({a_halted, a_state, a_pc_load, a_write} !== {1'b1, 2'd3, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL trap_enter: halted=%b st=%0d pc=%b wr=%b expected halted=1 st=3 pc=0 wr=0",
        a_halted, a_state, a_pc_load, a_write); end
    n_checks++; if ({b_halted, b_state, b_pc_load, b_write} !== {1'b0, 2'd3, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL nop_commit: halted=%b st=%0d pc=%b wr=%b expected halted=0 st=3 pc=1 wr=0",
        b_halted, b_state, b_pc_load, b_write); end
    step(1);
    n_checks++; if ({b_state, b_retired} !== {2'd0, 4'd8})
      begin n_fail++; $display("FAIL nop_retired: st=%0d retired=%0d expected st=0 retired=8", b_state, b_retired); end
    run = 1'b1; opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 6; i++) begin
      step(1);
      n_checks++; if ({a_halted, a_state, a_pc_load} !== {1'b1, 2'd3, 1'b0})
        begin n_fail++; $display("FAIL trap_hold_%0d: halted=%b st=%0d pc=%b expected halted=1 st=3 pc=0",
          i, a_halted, a_state, a_pc_load); end
    end
    run = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++; if ({a_halted, a_state, a_retired, b_retired} !== {1'b0, 2'd0, 32'd0, 4'd0})
      begin n_fail++; $display("FAIL trap_reset: halted=%b st=%0d a_ret=%0d b_ret=%0d expected 0 0 0 0",
        a_halted, a_state, a_retired, b_retired); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_wrap;
    run = 1'b1; opcode = 6'h00; funct = 6'h3F;
    step(60);
    n_checks++; if ({b_state, b_retired} !== {2'd0, 4'd15})
      begin n_fail++; $display("FAIL wrap_preload: st=%0d retired=%0d expected st=0 retired=15", b_state, b_retired); end
    n_checks++; if (a_halted !== 1'b1) begin n_fail++; $display("FAIL rtype_bad_funct_trap: got %b expected 1", a_halted); end
    step(3);
    n_checks++; if ({b_pc_load, b_write, b_rd_mux_s, b_alu_funct, b_retired} !== {1'b1, 1'b0, 1'b0, 6'h00, 4'd15})
      begin n_fail++; $display("FAIL wrap_commit: pc=%b wr=%b rd=%b alu=%h retired=%0d expected pc=1 wr=0 rd=0 alu=00 retired=15",
        b_pc_load, b_write, b_rd_mux_s, b_alu_funct, b_retired); end
    run = 1'b0;
    step(1);
    n_checks++; if (b_retired !== 4'd0) begin n_fail++; $display("FAIL wrap_to_zero: got %0d expected 0", b_retired); end
  endtask

  task automatic test_reset_in_commit;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1; run = 1'b1; opcode = 6'h08; funct = 6'h00;
    step(1);
    run = 1'b0;
    step(2);
    n_checks++; if ({a_write, a_pc_load} !== 2'b11)
      begin n_fail++; $display("FAIL rst_commit_pre: wr=%b pc=%b expected wr=1 pc=1", a_write, a_pc_load); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({a_write, a_pc_load, a_state, a_retired, b_write} !== {1'b0, 1'b0, 2'd0, 32'd0, 1'b0})
      begin n_fail++; $display("FAIL rst_commit_drop: wr=%b pc=%b st=%0d retired=%0d b_wr=%b expected 0 0 0 0 0",
        a_write, a_pc_load, a_state, a_retired, b_write); end
    @(posedge clock);
    #1;
    n_checks++; if ({a_state, a_retired} !== {2'd0, 32'd0})
      begin n_fail++; $display("FAIL rst_commit_hold: st=%0d retired=%0d expected st=0 retired=0", a_state, a_retired); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    test_reset;
    test_rtype_add;
    test_back_to_back;
    test_branch;
    test_run_stall;
    test_trap;
    test_wrap;
    test_reset_in_commit;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
